// File: rtl/round_sat_pipe_if.sv
// round_sat_pipe_if: sample, mode and result bundle for the rounding/saturating pipeline
interface round_sat_pipe_if #(
  parameter int DIN_WIDTH  = 12,
  parameter int DOUT_WIDTH = 10,
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 16
);
  logic [CHANNELS*DIN_WIDTH-1:0]  din;
  logic                           din_ce;
  logic [1:0]                     mode;
  logic                           sat_cnt_clr;
  logic [CHANNELS*DOUT_WIDTH-1:0] dout;
  logic                           dout_valid;
  logic [CHANNELS-1:0]            ovf;
  logic [CNT_WIDTH-1:0]           sat_cnt;
  modport master (
    output din, din_ce, mode, sat_cnt_clr,
    input  dout, dout_valid, ovf, sat_cnt
  );
  modport slave (
    input  din, din_ce, mode, sat_cnt_clr,
    output dout, dout_valid, ovf, sat_cnt
  );
endinterface

// File: rtl/round_sat_pipe.sv
// round_sat_pipe: two-stage multi-lane rounding/saturating width reducer; ROUND_SAT_PIPE_SAT_CNT_EN builds the saturation counter
module round_sat_pipe #(
  parameter int DIN_WIDTH  = 12,
  parameter int DOUT_WIDTH = 10,
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  round_sat_pipe_if.slave bus
);
  localparam int D  = DIN_WIDTH - DOUT_WIDTH;
  localparam int SW = DIN_WIDTH + 1;
  localparam int QW = DOUT_WIDTH + 1;
  localparam logic [SW-1:0] H = SW'(1) << (D - 1);
  logic [CHANNELS*QW-1:0] q_d, q_r;
  logic [CHANNELS*DOUT_WIDTH-1:0] y_d;
  logic [CHANNELS-1:0] o_d;
  logic v1;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [SW-1:0] x, s;
    logic [QW-1:0] q;
    logic unused_lsb;
    assign x = {bus.din[k*DIN_WIDTH+DIN_WIDTH-1], bus.din[k*DIN_WIDTH +: DIN_WIDTH]};
    assign s = bus.mode == 2'd0 ? x :
               bus.mode == 2'd1 ? x + H :
               bus.mode == 2'd2 ? x + H - SW'(x[SW-1]) :
                                  x + H - SW'(1) + SW'(x[D]);
    // the dropped fraction only matters through the carry already folded into s
    assign q_d[k*QW +: QW] = s[SW-1:D];
    assign unused_lsb = ^s[D-1:0];
    assign q = q_r[k*QW +: QW];
    assign o_d[k] = q[QW-1] ^ q[QW-2];
    assign y_d[k*DOUT_WIDTH +: DOUT_WIDTH] = o_d[k] ? {q[QW-1], {(DOUT_WIDTH-1){~q[QW-1]}}}
                                                    : q[DOUT_WIDTH-1:0];
  end
  always_ff @(posedge clk)
    if (rst) begin
      v1             <= 1'b0;
      q_r            <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.ovf        <= '0;
    end else begin
      v1             <= bus.din_ce;
      bus.dout_valid <= v1;
      if (bus.din_ce) q_r <= q_d;
      if (v1) begin
        bus.dout <= y_d;
        bus.ovf  <= o_d;
      end
    end
`ifdef ROUND_SAT_PIPE_SAT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || bus.sat_cnt_clr) cnt <= '0;
    else if (bus.dout_valid && |bus.ovf && !(&cnt)) cnt <= cnt + CNT_WIDTH'(1);
  assign bus.sat_cnt = cnt;
`else
  logic unused_clr;
  assign unused_clr = bus.sat_cnt_clr;
  assign bus.sat_cnt = '0;
`endif
endmodule

// File: tb/tb_round_sat_pipe.sv
// tb_round_sat_pipe: directed vector checks of rounding modes, saturation, latency, counter and reset flush
module tb_round_sat_pipe;
`ifdef ROUND_SAT_PIPE_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct {
    logic [11:0] x;
    logic [1:0]  m;
    logic [9:0]  y;
    logic        o;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  round_sat_pipe_if bus_i ();
  round_sat_pipe dut (.clk(clk), .rst(rst), .bus(bus_i));
  int errors = 0;
  int checks = 0;
  int cnt_exp = 0;
  vec_t tv [23];
  logic [11:0] xs [5] = '{12'd5, 12'd6, 12'd10, 12'hFFA, 12'd2};
  int ex [4][5] = '{'{1, 1, 2, -2, 0}, '{1, 2, 3, -1, 1}, '{1, 2, 3, -2, 1}, '{1, 2, 2, -2, 0}};
  logic [11:0] b0 [8] = '{12'h7FE, 12'h005, 12'hFFA, 12'h800, 12'h00A, 12'h7FF, 12'h003, 12'hF02};
  logic [11:0] b1 [8] = '{12'h006, 12'h7FD, 12'h002, 12'hFF9, 12'h7FA, 12'h80F, 12'h00E, 12'h401};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [11:0] x0, input logic [11:0] x1, input logic [1:0] m, input logic ce);
    bus_i.din    = {x1, x0};
    bus_i.mode   = m;
    bus_i.din_ce = ce;
  endtask
  function automatic logic [10:0] model(input logic [11:0] xin, input logic [1:0] m);
    int x, f, r, q;
    bit up;
    x = int'(signed'(xin));
    f = x >= 0 ? x / 4 : -((-x + 3) / 4);
    r = x - 4 * f;
    up = m == 2'd1 ? r >= 2 :
         m == 2'd2 ? (r > 2 || (r == 2 && x >= 0)) :
         m == 2'd3 ? (r > 2 || (r == 2 && f % 2 != 0)) : 1'b0;
    q = f + int'(up);
    if (q > 511) return {1'b1, 10'h1FF};
    if (q < -512) return {1'b1, 10'h200};
    return {1'b0, q[9:0]};
  endfunction
  function automatic logic [31:0] cnt_ref();
    return CNT_EN ? 32'(cnt_exp) : 32'd0;
  endfunction
  task automatic bump(input logic any);
    if (any && cnt_exp < 65535) cnt_exp++;
  endtask
  task automatic apply(input logic [11:0] x0, input logic [11:0] x1, input logic [1:0] m,
                       output logic [19:0] d, output logic [1:0] o);
    drive(x0, x1, m, 1'b1);
    tick;
    drive(x0, x1, m, 1'b0);
    chk("valid_early", 32'(bus_i.dout_valid), 32'd0);
    tick;
    chk("valid_pulse", 32'(bus_i.dout_valid), 32'd1);
    d = bus_i.dout;
    o = bus_i.ovf;
    tick;
    chk("valid_drop", 32'(bus_i.dout_valid), 32'd0);
  endtask
  initial begin
    logic [19:0] d;
    logic [1:0] o;
    logic [10:0] e0, e1;
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 5; i++)
        tv[m*5+i] = '{xs[i], 2'(m), 10'(ex[m][i]), 1'b0};
    tv[20] = '{12'h7FE, 2'd1, 10'h1FF, 1'b1};
    tv[21] = '{12'h7FE, 2'd0, 10'h1FF, 1'b0};
    tv[22] = '{12'h800, 2'd3, 10'h200, 1'b0};
    bus_i.sat_cnt_clr = 1'b0;
    drive(12'h123, 12'h456, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("reset_out", {9'd0, bus_i.dout_valid, bus_i.ovf, bus_i.dout}, 32'd0);
      chk("reset_cnt", 32'(bus_i.sat_cnt), 32'd0);
    end
    rst = 1'b0;
    apply(12'd6, 12'd0, 2'd1, d, o);
    chk("latency_lane0", 32'(d[9:0]), 32'd2);
    chk("hold_dout", 32'(bus_i.dout), 32'(d));
    for (int i = 0; i < 23; i++) begin
      apply(tv[i].x, tv[i].x ^ 12'h555, tv[i].m, d, o);
      e1 = model(tv[i].x ^ 12'h555, tv[i].m);
      chk($sformatf("vec%0d_lane0", i), 32'(d[9:0]), 32'(tv[i].y));
      chk($sformatf("vec%0d_ovf0", i), 32'(o[0]), 32'(tv[i].o));
      chk($sformatf("vec%0d_lane1", i), {o[1], d[19:10]}, 32'(e1));
      bump(tv[i].o | e1[10]);
      chk($sformatf("vec%0d_satcnt", i), 32'(bus_i.sat_cnt), cnt_ref());
    end
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(b0[i], b1[i], 2'(i * 3), 1'b1);
      else drive(12'd0, 12'd0, 2'd0, 1'b0);
      tick;
      if (i > 0) begin
        e0 = model(b0[i-1], 2'((i - 1) * 3));
        e1 = model(b1[i-1], 2'((i - 1) * 3));
        chk($sformatf("b2b%0d_valid", i - 1), 32'(bus_i.dout_valid), 32'd1);
        chk($sformatf("b2b%0d_dout", i - 1), 32'(bus_i.dout), 32'({e1[9:0], e0[9:0]}));
        chk($sformatf("b2b%0d_ovf", i - 1), 32'(bus_i.ovf), 32'({e1[10], e0[10]}));
        bump(e0[10] | e1[10]);
      end
    end
    tick;
    chk("b2b_valid_end", 32'(bus_i.dout_valid), 32'd0);
    chk("b2b_satcnt", 32'(bus_i.sat_cnt), cnt_ref());
`ifdef ROUND_SAT_PIPE_SAT_CNT_EN
    drive(12'h7FE, 12'd0, 2'd1, 1'b1);
    for (int i = 0; i < 65541; i++) begin
      tick;
      bump(1'b1);
    end
    drive(12'd0, 12'd0, 2'd0, 1'b0);
    tick;
    tick;
    tick;
    chk("satcnt_sticky", 32'(bus_i.sat_cnt), 32'hFFFF);
`endif
    drive(12'h7FE, 12'd0, 2'd1, 1'b1);
    tick;
    drive(12'h7FE, 12'd0, 2'd1, 1'b0);
    tick;
    chk("clr_ovf", 32'(bus_i.ovf), 32'd1);
    bus_i.sat_cnt_clr = 1'b1;
    tick;
    bus_i.sat_cnt_clr = 1'b0;
    cnt_exp = 0;
    chk("clr_priority", 32'(bus_i.sat_cnt), 32'd0);
    apply(12'h7FF, 12'd0, 2'd2, d, o);
    bump(1'b1);
    chk("cnt_after_clr", 32'(bus_i.sat_cnt), cnt_ref());
    drive(12'h100, 12'h0F0, 2'd0, 1'b1);
    tick;
    drive(12'h100, 12'h0F0, 2'd0, 1'b0);
    rst = 1'b1;
    tick;
    chk("flush_valid", 32'(bus_i.dout_valid), 32'd0);
    chk("flush_dout", 32'(bus_i.dout), 32'd0);
    chk("flush_ovf", 32'(bus_i.ovf), 32'd0);
    chk("flush_cnt", 32'(bus_i.sat_cnt), 32'd0);
    rst = 1'b0;
    tick;
    chk("flush_valid_after", 32'(bus_i.dout_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
